// File: rtl/fifo_flagged.sv
// Register-based FIFO with occupancy count, threshold flags,
// show-ahead or registered read data, flush and sticky error flags.
module fifo_flagged #(
   parameter int WIDTH     = 512,
   parameter int LOG_DEPTH = 9,
   parameter bit SHOWAHEAD = 1'b1,
   parameter int AF_THRESH = (1 << LOG_DEPTH) - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 wrreq,
   input  logic [WIDTH-1:0]     data,
   output logic                 full,
   output logic                 almost_full,
   input  logic                 rdreq,
   output logic [WIDTH-1:0]     q,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [LOG_DEPTH:0]   usedw,
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 err_clr
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   localparam logic [LOG_DEPTH:0] FULL_LVL =
      (LOG_DEPTH+1)'(DEPTH);
   localparam logic [LOG_DEPTH:0] AF_LVL =
      (LOG_DEPTH+1)'(AF_THRESH);
   localparam logic [LOG_DEPTH:0] AE_LVL =
      (LOG_DEPTH+1)'(AE_THRESH);
   localparam logic [LOG_DEPTH:0] CNT_ONE =
      (LOG_DEPTH+1)'(1);
   localparam logic [LOG_DEPTH-1:0] PTR_ONE =
      LOG_DEPTH'(1);

   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic [LOG_DEPTH:0]   usedw_q, usedw_d;
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic                 wr_acc, rd_acc;

   assign full         = (usedw_q == FULL_LVL);
   assign empty        = (usedw_q == '0);
   assign almost_full  = (usedw_q >= AF_LVL);
   assign almost_empty = (usedw_q <= AE_LVL);
   assign usedw        = usedw_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // Flush suppresses both accepts so nothing moves that cycle.
   assign wr_acc = wrreq & ~full  & ~clear;
   assign rd_acc = rdreq & ~empty & ~clear;

   always_comb begin
      usedw_d  = usedw_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         usedw_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (wr_acc && !rd_acc)
            usedw_d = usedw_q + CNT_ONE;
         else if (rd_acc && !wr_acc)
            usedw_d = usedw_q - CNT_ONE;
      end
   end

   // A new error in the same cycle as err_clr stays visible.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (wrreq && full && !clear)  ovf_d = 1'b1;
      if (rdreq && empty && !clear) unf_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         usedw_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         usedw_q  <= usedw_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wr_ptr_q] <= data;
   end

   if (SHOWAHEAD) begin : g_showahead
      assign q = mem_q[rd_ptr_q];
   end else begin : g_registered
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)    q_q <= '0;
         else if (rd_acc) q_q <= mem_q[rd_ptr_q];
      end
      assign q = q_q;
   end

endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard bench for fifo_flagged: show-ahead and registered
// instances share stimulus and are compared with a queue model.
module tb_fifo_flagged;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       clear = 1'b0;
   logic       wrreq = 1'b0;
   logic       rdreq = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data = 8'h00;

   logic       sa_full, sa_af, sa_empty, sa_ae, sa_ovf, sa_unf;
   logic       rg_full, rg_af, rg_empty, rg_ae, rg_ovf, rg_unf;
   logic [7:0] sa_q, rg_q;
   logic [2:0] sa_usedw, rg_usedw;

   int checks = 0;
   int failures = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_sa[$];
   logic [7:0] exp_rg[$];
   logic [8:0] fq[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic       mon_en = 1'b1;
   logic       rg_pend = 1'b0;
   logic [7:0] rg_hold = 8'h00;

   always #5 clock = ~clock;

   fifo_flagged #(
      .WIDTH(8), .LOG_DEPTH(2), .SHOWAHEAD(1'b1),
      .AF_THRESH(3), .AE_THRESH(1)
   ) dut_sa (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .wrreq(wrreq), .data(data), .full(sa_full),
      .almost_full(sa_af), .rdreq(rdreq), .q(sa_q),
      .empty(sa_empty), .almost_empty(sa_ae),
      .usedw(sa_usedw), .overflow(sa_ovf),
      .underflow(sa_unf), .err_clr(err_clr)
   );

   fifo_flagged #(
      .WIDTH(8), .LOG_DEPTH(2), .SHOWAHEAD(1'b0),
      .AF_THRESH(3), .AE_THRESH(1)
   ) dut_rg (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .wrreq(wrreq), .data(data), .full(rg_full),
      .almost_full(rg_af), .rdreq(rdreq), .q(rg_q),
      .empty(rg_empty), .almost_empty(rg_ae),
      .usedw(rg_usedw), .overflow(rg_ovf),
      .underflow(rg_unf), .err_clr(err_clr)
   );

   task automatic check(input string name,
                        input logic [15:0] act,
                        input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the model works from occupancy alone.
   task automatic cycle(input logic w, input logic [7:0] d,
                        input logic r, input logic c,
                        input logic e);
      int n;
      logic [7:0] v;
      @(posedge clock);
      #1;
      wrreq = w; data = d; rdreq = r;
      clear = c; err_clr = e;
      n = mq.size();
      fq.push_back({3'(n), n == 4, n >= 3, n == 0,
                    n <= 1, m_ovf, m_unf});
      if (e) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (c) begin
         mq.delete();
      end else begin
         if (w && n == 4) m_ovf = 1'b1;
         if (r && n == 0) m_unf = 1'b1;
         if (r && n > 0) begin
            v = mq.pop_front();
            exp_sa.push_back(v);
            exp_rg.push_back(v);
         end
         if (w && n < 4) mq.push_back(d);
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(0, 8'h00, 0, 0, 0);
   endtask

   always @(negedge clock) begin
      logic [8:0] ef;
      logic [7:0] v;
      if (mon_en && fq.size() > 0) begin
         ef = fq.pop_front();
         check("flags_sa",
               16'({sa_usedw, sa_full, sa_af, sa_empty,
                    sa_ae, sa_ovf, sa_unf}), 16'(ef));
         check("flags_rg",
               16'({rg_usedw, rg_full, rg_af, rg_empty,
                    rg_ae, rg_ovf, rg_unf}), 16'(ef));
         if (rg_pend) begin
            if (exp_rg.size() == 0) begin
               check("rg_q_unexpected", 16'(rg_q), 16'hxxxx);
            end else begin
               v = exp_rg.pop_front();
               rg_hold = v;
               check("rg_q_read", 16'(rg_q), 16'(v));
            end
         end else begin
            check("rg_q_hold", 16'(rg_q), 16'(rg_hold));
         end
         rg_pend = rdreq && !rg_empty && !clear;
         if (rdreq && !sa_empty && !clear) begin
            if (exp_sa.size() == 0) begin
               check("sa_q_unexpected", 16'(sa_q), 16'hxxxx);
            end else begin
               v = exp_sa.pop_front();
               check("sa_q_read", 16'(sa_q), 16'(v));
            end
         end
      end
   end

   initial begin
      #2;
      check("rst_rg_q", 16'(rg_q), 16'h0000);
      check("rst_usedw", 16'(sa_usedw), 16'h0000);
      #10 reset_n = 1'b1;

      // fill, then full boundary, then drain
      cycle(1, 8'hA1, 0, 0, 0);
      cycle(1, 8'hA2, 0, 0, 0);
      cycle(1, 8'hA3, 0, 0, 0);
      cycle(1, 8'hA4, 0, 0, 0);
      idle(1);
      cycle(1, 8'hEE, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      idle(2);

      // empty reads and error clearing
      cycle(0, 8'h00, 1, 0, 0);
      idle(1);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 1);
      idle(1);
      cycle(0, 8'h00, 0, 0, 1);

      // wrap-around with usedw kept small
      cycle(1, 8'h11, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         cycle(1, 8'(8'h12 + i), 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      idle(2);

      // registered-mode hold
      cycle(1, 8'h55, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      idle(3);

      // flush with a write pending
      cycle(1, 8'h31, 0, 0, 0);
      cycle(1, 8'h32, 0, 0, 0);
      cycle(1, 8'h33, 0, 0, 0);
      cycle(1, 8'h34, 0, 1, 0);
      idle(2);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 9) < 6, 8'($urandom),
               $urandom_range(0, 9) < 5,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) == 0);
      idle(2);

      // leave state non-trivial, then reset mid-cycle
      for (int i = 0; i < 5; i++)
         cycle(1, 8'(8'hC0 + i), 0, 0, 0);
      idle(1);
      @(posedge clock);
      #3;
      mon_en = 1'b0;
      reset_n = 1'b0;
      #1;
      check("arst_flags_sa",
            16'({sa_usedw, sa_full, sa_af, sa_empty,
                 sa_ae, sa_ovf, sa_unf}),
            16'({3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
      check("arst_flags_rg",
            16'({rg_usedw, rg_full, rg_af, rg_empty,
                 rg_ae, rg_ovf, rg_unf}),
            16'({3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
      check("arst_rg_q", 16'(rg_q), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Parametrised register-based (non-block-RAM) FIFO; next generation of the team's simulation-friendly FIFO.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, a selectable show-ahead or registered read mode, synchronous flush, and sticky overflow/underflow error flags.
- Sits between application-side producers/consumers and the memory/host interface queues wherever back-pressure needs early warning.

Parameters:
- WIDTH, 512, data bits per entry.
- LOG_DEPTH, 9, log2 of entry count; DEPTH = 2^LOG_DEPTH; legal range ≥1.
- SHOWAHEAD, 1, 1 = head word visible on q combinationally; 0 = q registered, updated one cycle after read accept.
- AF_THRESH, DEPTH-4, almost_full asserted when usedw ≥ AF_THRESH; legal 1..DEPTH.
- AE_THRESH, 4, almost_empty asserted when usedw ≤ AE_THRESH; legal 0..DEPTH-1.

Ports:
- clock, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous flush.
- wrreq, in, 1, enqueue request.
- data, in, WIDTH, write data.
- full, out, 1, usedw == DEPTH.
- almost_full, out, 1, usedw ≥ AF_THRESH.
- rdreq, in, 1, dequeue request.
- q, out, WIDTH, read data.
- empty, out, 1, usedw == 0.
- almost_empty, out, 1, usedw ≤ AE_THRESH.
- usedw, out, LOG_DEPTH+1, current occupancy, 0..DEPTH.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
- err_clr, in, 1, clears the sticky error flags.

Behaviour:
- Reset (reset_n low, asynchronous):
  - usedw, rd_ptr, wr_ptr, overflow, underflow = 0.
  - Flags follow from usedw = 0: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - q = 0 when SHOWAHEAD = 0.
  - Storage array is not reset.
- Release: synchronous to clock; first accept possible on the first rising edge with reset_n high.
- Accept rules (evaluated on registered state only):
  - wr_acc = wrreq & ~full.
  - rd_acc = rdreq & ~empty.
  - Write while full is dropped even when a read is accepted in the same cycle.
  - Read while empty is ignored even when a write is accepted in the same cycle; there is no write-to-read bypass.
- Counter and pointer updates:
  - wr_acc & rd_acc: usedw unchanged; both pointers +1.
  - wr_acc only: usedw +1.
  - rd_acc only: usedw -1.
  - Pointers are LOG_DEPTH bits and wrap modulo DEPTH with no special case.
- Flags: all combinational from registered usedw, so they change the cycle after the accepting edge. empty deasserts on the cycle after the first write.
- Read data, SHOWAHEAD = 1:
  - q = mem[rd_ptr] combinationally.
  - Valid whenever empty = 0; don't-care when empty.
- Read data, SHOWAHEAD = 0:
  - On rd_acc, q <= mem[rd_ptr] at that edge, so data is on q the cycle after rdreq.
  - q holds its value otherwise, including across clear.
- clear:
  - At the edge it is sampled high: usedw, rd_ptr, wr_ptr <= 0.
  - Overrides wrreq/rdreq: nothing is accepted that cycle, no error flag is set that cycle, and q is untouched.
- Sticky errors:
  - overflow <= 1 on wrreq & full & ~clear.
  - underflow <= 1 on rdreq & empty & ~clear.
  - Cleared by err_clr; if set and clear conditions coincide, set wins.
  - clear does not clear the error flags; only reset_n and err_clr do.
- Reset mid-operation: all state is lost immediately and asynchronously, whatever handshakes are in flight.

Test Plan (WIDTH=8, LOG_DEPTH=2, AF_THRESH=3, AE_THRESH=1):
- Fill and drain, SHOWAHEAD=1:
  - Write 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → usedw steps 1, 2, 3, 4; almost_empty drops at usedw = 2; almost_full rises at 3; full at 4; q = 0xA1 throughout.
  - Read 4 → q = 0xA2, 0xA3, 0xA4; empty = 1 at the end.
- Full boundary: at full, wrreq=1 and rdreq=1 → read accepted, write dropped; usedw = 3; overflow = 1 next cycle.
- Wrap-around: write 6 and read 6 interleaved, keeping usedw ≤ 2 → output sequence matches input exactly; pointers wrap past 3 → 0.
- Registered mode, SHOWAHEAD=0: write 0x55, then rdreq one cycle → q = 0x55 on the following cycle; q holds 0x55 after further idle cycles.
- Empty read plus err_clr:
  - rdreq on empty → underflow = 1.
  - err_clr alone → underflow = 0.
  - err_clr together with rdreq on empty → underflow stays 1.
- clear and reset:
  - With usedw = 3, assert clear with wrreq=1 → usedw = 0 and empty = 1 next cycle; no write accepted.
  - Assert reset_n low mid-cycle → outputs go to reset values immediately, before the next clock edge.
